account_ledger: RTL and testbench
=================================

# account_ledger

Bank-side responder for the cashier's transaction path. On card insertion it looks up the account balance in a small on-chip register array and serves it as `balance_inicial`. It then waits for the transaction engine's outcome: it writes back `balance_actualizado` on `balance_stb`, releases with no write on `fondos_insuficientes`, and aborts on timeout. An idle-only preload port lets the host initialise balances.

## Interface
- `N_CUENTAS`, 6: number of accounts; valid ids are 0..N_CUENTAS-1.
- `ID_W`, 3: account id width.
- `BAL_W`, 64: balance width; matches the transaction engine's `balance_inicial`/`balance_actualizado`.
- `TIMEOUT`, 16: SERVIR cycles allowed before abort; must be ≥ 2.
- `clk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `tarjeta_recibida`  in  1  level; card present, session request.
- `id_cuenta`  in  ID_W  account id; sampled in IDLE with `tarjeta_recibida`.
- `balance_actualizado`  in  BAL_W  new balance from the transaction engine.
- `balance_stb`  in  1  commit strobe for `balance_actualizado`.
- `fondos_insuficientes`  in  1  transaction rejected; end session without write.
- `carga_en`  in  1  preload write enable; honoured only in IDLE.
- `carga_id`  in  ID_W  preload target account.
- `carga_valor`  in  BAL_W  preload value.
- `balance_inicial`  out  BAL_W  served balance; registered.
- `balance_valido`  out  1  high while `balance_inicial` is valid (SERVIR).
- `ocupado`  out  1  high in every state except IDLE.
- `escritura_ok`  out  1  one-cycle pulse after a committed write-back.
- `error_timeout`  out  1  one-cycle pulse on session timeout.
- `cuenta_invalida`  out  1  one-cycle pulse when the id is out of range.

## Operation
- States: IDLE, LEER, SERVIR.
- IDLE:
  - If `carga_en`: `mem[carga_id] <= carga_valor`. An out-of-range `carga_id` is ignored. `carga_en` takes priority over `tarjeta_recibida`, which is ignored that cycle.
  - Otherwise, if `tarjeta_recibida`: latch `id_cuenta` into `id_q` and go to LEER.
- LEER, one cycle:
  - If `id_q >= N_CUENTAS`: pulse `cuenta_invalida` and return to IDLE.
  - Otherwise: `balance_inicial <= mem[id_q]`, clear the timer, and go to SERVIR.
- SERVIR: `balance_valido=1` and the timer increments each cycle. Priority, highest first:
  1. `fondos_insuficientes`: go to IDLE, no write.
  2. `balance_stb`: `mem[id_q] <= balance_actualizado` (full BAL_W, no arithmetic), pulse `escritura_ok`, go to IDLE.
  3. Timer reaches TIMEOUT-1: pulse `error_timeout`, go to IDLE, no write.
- `carga_en` is ignored outside IDLE.
- `balance_inicial` holds its last value after the session ends. It is only meaningful while `balance_valido` is high.
- `tarjeta_recibida` still high on return to IDLE starts a new session on the next edge. This is intended, because the card is a level signal.
- Reset values: state IDLE, all memory entries 0, `balance_inicial` 0, `id_q` 0, timer 0, every 1-bit output 0.
- Reset asserted in any state returns to IDLE on that edge and discards pending writes. A `balance_stb` in the same cycle as reset does not write.

## Timing
- `tarjeta_recibida` sampled at edge k: LEER after edge k, SERVIR after edge k+1, so `balance_valido` and `balance_inicial` are valid from edge k+1. Read latency is 2 cycles.
- `balance_stb` sampled at edge m: memory updated at edge m, `escritura_ok` high during cycle m..m+1, state IDLE after edge m. The earliest new session reads the updated value.
- Timeout: with no response, `error_timeout` pulses exactly TIMEOUT cycles after entering SERVIR.
- Preload at edge p is visible to a session whose LEER state follows edge p.
- `ocupado` is registered from state: high from edge k through the edge that returns to IDLE.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Package `cajero_pkg`:
  - state encoding `estado_ledger_t` (IDLE, LEER, SERVIR);
  - default BAL_W/ID_W constants;
  - `deposito`/`retiro` codes, shared with the transaction engine.
- One sub-module, `ledger_mem`: an N_CUENTAS×BAL_W register array with synchronous reset to 0, one write port (arbitrated by the FSM between preload and commit) and one combinational read port.
- FSM, timer and output registers live in `account_ledger`.

## Test plan
- Preload `carga_en` with id 2, value 1000. Then `tarjeta_recibida` with id 2 → `balance_valido` two edges later and `balance_inicial`=1000.
- Session on id 2, then `balance_stb` with `balance_actualizado`=700 → `escritura_ok` pulse. A new session on id 2 serves 700.
- Session on id 2, then `fondos_insuficientes` in the same cycle as `balance_stb` with `balance_actualizado`=0 → no write, no `escritura_ok`. The next read is still 700.
- Session with no response → `error_timeout` exactly 16 cycles after `balance_valido` rises, `ocupado` drops, balance unchanged.
- `id_cuenta`=7 (≥6) → `cuenta_invalida` pulse one cycle after acceptance, `balance_valido` never asserts. `carga_en` to id 7 has no effect.
- Reset mid-SERVIR coincident with `balance_stb` → all outputs 0, all balances 0. `carga_en` during SERVIR is ignored, and `tarjeta_recibida` together with `carga_en` in IDLE performs only the preload.

Source files
------------

// File: rtl/cajero_pkg.sv
// rtl/cajero_pkg.sv - shared types and constants for the cashier transaction path
//
// Contents:
//   estado_ledger_t   account_ledger FSM state encoding
//   BAL_W_DEF/ID_W_DEF default balance and account-id widths
//   operacion_t       deposit/withdraw codes shared with the transaction engine
package cajero_pkg;

    localparam int BAL_W_DEF = 64;
    localparam int ID_W_DEF  = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LEER   = 2'd1,
        SERVIR = 2'd2
    } estado_ledger_t;

    typedef enum logic {
        OP_DEPOSITO = 1'b0,
        OP_RETIRO   = 1'b1
    } operacion_t;

endpackage

// File: rtl/ledger_mem.sv
// rtl/ledger_mem.sv - N_CUENTAS x BAL_W balance register array
//
// Ports:
//   clk, reset       clock; synchronous active-low reset clears every entry
//   we_i             write enable (single port, arbitrated by the owner FSM)
//   waddr_i/wdata_i  write address and data; out-of-range addresses are dropped
//   raddr_i          combinational read address
//   rdata_o          read data; 0 for out-of-range addresses
module ledger_mem #(
    parameter int N_CUENTAS = 6,
    parameter int ID_W      = 3,
    parameter int BAL_W     = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we_i,
    input  logic [ID_W-1:0]  waddr_i,
    input  logic [BAL_W-1:0] wdata_i,
    input  logic [ID_W-1:0]  raddr_i,
    output logic [BAL_W-1:0] rdata_o
);

    localparam logic [ID_W:0] N_LIM = (ID_W+1)'(N_CUENTAS);

    logic [BAL_W-1:0] mem_q [N_CUENTAS];

    logic waddr_ok;
    logic raddr_ok;

    assign waddr_ok = ({1'b0, waddr_i} < N_LIM);
    assign raddr_ok = ({1'b0, raddr_i} < N_LIM);

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < N_CUENTAS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && waddr_ok) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = raddr_ok ? mem_q[raddr_i] : '0;

endmodule

// File: rtl/account_ledger.sv
// rtl/account_ledger.sv - bank-side balance responder for the cashier transaction path
//
// Ports:
//   clk, reset                 clock; synchronous active-low reset
//   tarjeta_recibida/id_cuenta session request (level) and account id, sampled in IDLE
//   balance_actualizado        new balance, committed on balance_stb
//   balance_stb                commit strobe
//   fondos_insuficientes       rejection; ends the session without a write
//   carga_en/carga_id/carga_valor  host preload port, honoured only in IDLE
//   balance_inicial            served balance (registered, meaningful with balance_valido)
//   balance_valido             high while serving
//   ocupado                    high in every state except IDLE
//   escritura_ok               one-cycle pulse after a committed write-back
//   error_timeout              one-cycle pulse when the engine never answers
//   cuenta_invalida            one-cycle pulse for an out-of-range account id
module account_ledger
    import cajero_pkg::*;
#(
    parameter int N_CUENTAS = 6,
    parameter int ID_W      = ID_W_DEF,
    parameter int BAL_W     = BAL_W_DEF,
    parameter int TIMEOUT   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tarjeta_recibida,
    input  logic [ID_W-1:0]  id_cuenta,
    input  logic [BAL_W-1:0] balance_actualizado,
    input  logic             balance_stb,
    input  logic             fondos_insuficientes,
    input  logic             carga_en,
    input  logic [ID_W-1:0]  carga_id,
    input  logic [BAL_W-1:0] carga_valor,
    output logic [BAL_W-1:0] balance_inicial,
    output logic             balance_valido,
    output logic             ocupado,
    output logic             escritura_ok,
    output logic             error_timeout,
    output logic             cuenta_invalida
);

    localparam int            TW         = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [ID_W:0] N_LIM      = (ID_W+1)'(N_CUENTAS);

    estado_ledger_t   state_q, state_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [BAL_W-1:0] bal_q, bal_d;
    logic             valido_q, ocupado_q, escritura_q, timeout_q, invalida_q;
    logic             escritura_d, timeout_d, invalida_d;

    logic             mem_we;
    logic [ID_W-1:0]  mem_waddr;
    logic [BAL_W-1:0] mem_wdata;
    logic [BAL_W-1:0] mem_rdata;

    ledger_mem #(
        .N_CUENTAS (N_CUENTAS),
        .ID_W      (ID_W),
        .BAL_W     (BAL_W)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (mem_wdata),
        .raddr_i (id_q),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        timer_d     = timer_q;
        bal_d       = bal_q;
        escritura_d = 1'b0;
        timeout_d   = 1'b0;
        invalida_d  = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = carga_id;
        mem_wdata   = carga_valor;

        case (state_q)
            IDLE: begin
                // Preload wins; a card arriving in the same cycle waits a cycle.
                if (carga_en) begin
                    mem_we = 1'b1;
                end else if (tarjeta_recibida) begin
                    id_d    = id_cuenta;
                    state_d = LEER;
                end
            end
            LEER: begin
                if ({1'b0, id_q} >= N_LIM) begin
                    invalida_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    bal_d   = mem_rdata;
                    timer_d = '0;
                    state_d = SERVIR;
                end
            end
            SERVIR: begin
                timer_d = timer_q + TW'(1);
                if (fondos_insuficientes) begin
                    state_d = IDLE;
                end else if (balance_stb) begin
                    mem_we      = 1'b1;
                    mem_waddr   = id_q;
                    mem_wdata   = balance_actualizado;
                    escritura_d = 1'b1;
                    state_d     = IDLE;
                end else if (timer_q == TIMER_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            id_q        <= '0;
            timer_q     <= '0;
            bal_q       <= '0;
            valido_q    <= 1'b0;
            ocupado_q   <= 1'b0;
            escritura_q <= 1'b0;
            timeout_q   <= 1'b0;
            invalida_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            timer_q     <= timer_d;
            bal_q       <= bal_d;
            valido_q    <= (state_d == SERVIR);
            ocupado_q   <= (state_d != IDLE);
            escritura_q <= escritura_d;
            timeout_q   <= timeout_d;
            invalida_q  <= invalida_d;
        end
    end

    assign balance_inicial = bal_q;
    assign balance_valido  = valido_q;
    assign ocupado         = ocupado_q;
    assign escritura_ok    = escritura_q;
    assign error_timeout   = timeout_q;
    assign cuenta_invalida = invalida_q;

endmodule

// File: tb/tb_account_ledger.sv
// tb/tb_account_ledger.sv - directed self-checking bench for account_ledger
module tb_account_ledger;

    logic        clk = 1'b0;
    logic        reset;
    logic        tarjeta_recibida;
    logic [2:0]  id_cuenta;
    logic [63:0] balance_actualizado;
    logic        balance_stb;
    logic        fondos_insuficientes;
    logic        carga_en;
    logic [2:0]  carga_id;
    logic [63:0] carga_valor;
    logic [63:0] balance_inicial;
    logic        balance_valido;
    logic        ocupado;
    logic        escritura_ok;
    logic        error_timeout;
    logic        cuenta_invalida;

    int n_asserts = 0;
    int n_fails   = 0;

    account_ledger #(
        .N_CUENTAS (6),
        .ID_W      (3),
        .BAL_W     (64),
        .TIMEOUT   (16)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .tarjeta_recibida     (tarjeta_recibida),
        .id_cuenta            (id_cuenta),
        .balance_actualizado  (balance_actualizado),
        .balance_stb          (balance_stb),
        .fondos_insuficientes (fondos_insuficientes),
        .carga_en             (carga_en),
        .carga_id             (carga_id),
        .carga_valor          (carga_valor),
        .balance_inicial      (balance_inicial),
        .balance_valido       (balance_valido),
        .ocupado              (ocupado),
        .escritura_ok         (escritura_ok),
        .error_timeout        (error_timeout),
        .cuenta_invalida      (cuenta_invalida)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Card for one edge (-> LEER), released, second edge (-> SERVIR or IDLE).
    task automatic open_session(input logic [2:0] id);
        tarjeta_recibida = 1'b1;
        id_cuenta        = id;
        step();
        tarjeta_recibida = 1'b0;
        step();
    endtask

    task automatic close_reject();
        fondos_insuficientes = 1'b1;
        step();
        fondos_insuficientes = 1'b0;
    endtask

    task automatic preload(input logic [2:0] id, input logic [63:0] val);
        carga_en    = 1'b1;
        carga_id    = id;
        carga_valor = val;
        step();
        carga_en    = 1'b0;
    endtask

    initial begin
        reset                = 1'b0;
        tarjeta_recibida     = 1'b0;
        id_cuenta            = '0;
        balance_actualizado  = '0;
        balance_stb          = 1'b0;
        fondos_insuficientes = 1'b0;
        carga_en             = 1'b0;
        carga_id             = '0;
        carga_valor          = '0;
        step();
        step();

        chk1 ("rst_valido",    balance_valido,  1'b0);
        chk1 ("rst_ocupado",   ocupado,         1'b0);
        chk1 ("rst_escritura", escritura_ok,    1'b0);
        chk1 ("rst_timeout",   error_timeout,   1'b0);
        chk1 ("rst_invalida",  cuenta_invalida, 1'b0);
        chk64("rst_balance",   balance_inicial, 64'd0);
        reset = 1'b1;
        step();

        // Preload then read: valid two edges after acceptance.
        preload(3'd2, 64'd1000);
        tarjeta_recibida = 1'b1;
        id_cuenta        = 3'd2;
        step();
        tarjeta_recibida = 1'b0;
        chk1 ("leer_ocupado", ocupado,        1'b1);
        chk1 ("leer_valido",  balance_valido, 1'b0);
        step();
        chk1 ("serv_valido",  balance_valido,  1'b1);
        chk64("serv_bal1000", balance_inicial, 64'd1000);

        // Commit 700.
        balance_actualizado = 64'd700;
        balance_stb         = 1'b1;
        step();
        balance_stb = 1'b0;
        chk1 ("commit_ok",      escritura_ok,    1'b1);
        chk1 ("commit_ocupado", ocupado,         1'b0);
        chk1 ("commit_valido",  balance_valido,  1'b0);
        chk64("commit_hold",    balance_inicial, 64'd1000);
        step();
        chk1 ("commit_pulse_end", escritura_ok, 1'b0);
        open_session(3'd2);
        chk64("read_700", balance_inicial, 64'd700);

        // Rejection outranks commit.
        balance_actualizado  = 64'd0;
        balance_stb          = 1'b1;
        fondos_insuficientes = 1'b1;
        step();
        balance_stb          = 1'b0;
        fondos_insuficientes = 1'b0;
        chk1("reject_no_ok",   escritura_ok, 1'b0);
        chk1("reject_ocupado", ocupado,      1'b0);
        open_session(3'd2);
        chk64("reject_still_700", balance_inicial, 64'd700);

        // Timeout: 16 edges after balance_valido rose.
        for (int i = 0; i < 15; i++) step();
        chk1("to_not_yet", error_timeout,  1'b0);
        chk1("to_valido",  balance_valido, 1'b1);
        step();
        chk1("to_pulse",   error_timeout,  1'b1);
        chk1("to_ocupado", ocupado,        1'b0);
        chk1("to_valido0", balance_valido, 1'b0);
        step();
        chk1("to_pulse_end", error_timeout, 1'b0);
        open_session(3'd2);
        chk64("to_still_700", balance_inicial, 64'd700);
        close_reject();

        // Out-of-range id and preload.
        preload(3'd7, 64'd55);
        tarjeta_recibida = 1'b1;
        id_cuenta        = 3'd7;
        step();
        tarjeta_recibida = 1'b0;
        chk1("inv_leer", cuenta_invalida, 1'b0);
        step();
        chk1("inv_pulse",   cuenta_invalida, 1'b1);
        chk1("inv_valido",  balance_valido,  1'b0);
        chk1("inv_ocupado", ocupado,         1'b0);
        step();
        chk1("inv_pulse_end", cuenta_invalida, 1'b0);
        chk1("inv_valido2",   balance_valido,  1'b0);
        open_session(3'd3);
        chk64("inv_id3_zero", balance_inicial, 64'd0);
        close_reject();

        // Last valid id, full-width value.
        preload(3'd5, 64'hFEDC_BA98_7654_3210);
        open_session(3'd5);
        chk64("id5_wide", balance_inicial, 64'hFEDC_BA98_7654_3210);
        close_reject();

        // Preload ignored during SERVIR.
        open_session(3'd2);
        preload(3'd2, 64'd999);
        close_reject();
        open_session(3'd2);
        chk64("serv_carga_ignored", balance_inicial, 64'd700);
        close_reject();

        // Card plus preload in IDLE: only the preload happens.
        carga_en         = 1'b1;
        carga_id         = 3'd2;
        carga_valor      = 64'd4321;
        tarjeta_recibida = 1'b1;
        id_cuenta        = 3'd2;
        step();
        carga_en         = 1'b0;
        tarjeta_recibida = 1'b0;
        chk1("both_idle", ocupado, 1'b0);
        step();
        chk1("both_idle2", ocupado, 1'b0);
        open_session(3'd2);
        chk64("both_preload", balance_inicial, 64'd4321);

        // Reset during SERVIR with a coincident commit.
        balance_actualizado = 64'd5555;
        balance_stb         = 1'b1;
        reset               = 1'b0;
        step();
        balance_stb = 1'b0;
        chk1 ("mrst_valido",  balance_valido,  1'b0);
        chk1 ("mrst_ocupado", ocupado,         1'b0);
        chk1 ("mrst_ok",      escritura_ok,    1'b0);
        chk64("mrst_balance", balance_inicial, 64'd0);
        reset = 1'b1;
        step();
        open_session(3'd2);
        chk1 ("mrst_id2_valido", balance_valido,  1'b1);
        chk64("mrst_id2_zero",   balance_inicial, 64'd0);
        close_reject();
        open_session(3'd5);
        chk64("mrst_id5_zero", balance_inicial, 64'd0);
        close_reject();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
